classify_sequencer: RTL and testbench
=====================================

CLASSIFY_SEQUENCER -- requirements
Module: classify_sequencer

Interface
REQ-001 Parameters SHALL be: NUM_DATA, default 40, feature words per sample; NUM_TREES, default 8, trees evaluated per sample; NUM_CLASSES, default 4, class labels; ADDR_W, default 14, memory address width; DATA_W, default 14, memory data width; TIMEOUT, default 1023, max cycles waiting on one tree.
REQ-002 Ports SHALL be, in order:
clk  in  1  single clock, all logic rising-edge
rst  in  1  reset, asynchronous, active-high
col_we  in  1  collector write strobe
col_addr  in  ADDR_W  collector write address
col_data  in  DATA_W  collector write data
col_finish  in  1  collector reports last word present
tree_start  out  1  one-cycle pulse, launch tree tree_idx
tree_idx  out  clog2(NUM_TREES)  tree being evaluated
tree_rd_req  in  1  tree engine read request
tree_rd_addr  in  ADDR_W  tree engine read address
tree_rd_valid  out  1  read data valid
tree_rd_data  out  DATA_W  read data
tree_done  in  1  one-cycle pulse, tree finished
tree_vote  in  clog2(NUM_CLASSES)  class voted by finished tree
mem_we  out  1  feature memory write enable
mem_addr  out  ADDR_W  feature memory address (single port)
mem_wdata  out  DATA_W  feature memory write data
mem_rdata  in  DATA_W  feature memory read data, 1-cycle latency
calced  out  1  one-cycle pulse, result ready
result_class  out  clog2(NUM_CLASSES)  majority class, held until next result
busy  out  1  high outside IDLE
err_overrun  out  1  sticky, write arrived outside COLLECT
err_timeout  out  1  sticky, a tree exceeded TIMEOUT

Function
REQ-003 FSM states SHALL be IDLE, COLLECT, LAUNCH, WAIT_TREE, TALLY, REPORT.
REQ-004 IDLE -> COLLECT on first col_we; that write SHALL be committed in the same cycle.
REQ-005 In COLLECT, col_we SHALL drive mem_we/mem_addr/mem_wdata combinationally from col_*; tree reads SHALL be ignored (tree_rd_valid low).
REQ-006 COLLECT -> LAUNCH on col_finish; a col_we coincident with col_finish SHALL be committed first.
REQ-007 LAUNCH SHALL assert tree_start for exactly one cycle with tree_idx = current tree counter (0 at first launch), then go to WAIT_TREE.
REQ-008 In WAIT_TREE, tree_rd_req SHALL drive mem_addr = tree_rd_addr, mem_we = 0; tree_rd_valid SHALL assert exactly one cycle after each accepted request with tree_rd_data = mem_rdata.
REQ-009 tree_done in WAIT_TREE SHALL add one vote to class tree_vote; tree_done in any other state SHALL be ignored.
REQ-010 A wait counter SHALL start at 0 on entering WAIT_TREE; reaching TIMEOUT without tree_done SHALL set err_timeout and record no vote.
REQ-011 After a vote or timeout: if tree counter = NUM_TREES-1 go to TALLY, else increment counter and go to LAUNCH.
REQ-012 TALLY SHALL select the class with the highest vote count in one cycle; ties SHALL resolve to the lowest class index; all-zero votes SHALL give class 0.
REQ-013 REPORT SHALL register result_class, pulse calced for one cycle, clear vote counters and tree counter, and return to IDLE.
REQ-014 col_we in any state except IDLE/COLLECT SHALL be dropped (mem_we low) and SHALL set err_overrun.
REQ-015 Vote counters SHALL be clog2(NUM_TREES+1) bits and never wrap.
REQ-016 busy SHALL be high in every state except IDLE.
REQ-017 Error flags SHALL clear only on rst.

Reset
REQ-018 On rst assertion, regardless of state: state=IDLE, counters and votes=0, tree_start=0, tree_rd_valid=0, tree_rd_data=0, mem_we=0, calced=0, result_class=0, busy=0, err_overrun=0, err_timeout=0.
REQ-019 A tree_done or col_we in the first cycle after rst deassertion SHALL be handled per IDLE rules.

Structure
REQ-020 State encoding and default parameter values SHALL live in shared package rf_pkg.
REQ-021 Vote counting and majority select SHALL be sub-module vote_tally (inputs add/vote/clear; output winner).

Verification
REQ-022 40 col_we writes, data = addr, col_finish on write 39 -> mem_we high 40 cycles, addresses 0..39, then tree_start with tree_idx=0.
REQ-023 8 trees voting 2,2,1,2,3,2,0,1 -> result_class=2, calced single pulse, busy low next cycle.
REQ-024 Votes 1,1,3,3,0,0,2,2 (4-way tie) -> result_class=0.
REQ-025 Tree 3 never asserts tree_done -> err_timeout set after 1023 cycles, sequence continues to tree 4, calced still pulses.
REQ-026 tree_rd_req at addr 5 after memory loaded with 0x1A5 -> tree_rd_valid next cycle with data 0x1A5; col_we during WAIT_TREE -> mem_we low, err_overrun=1.
REQ-027 rst asserted mid-WAIT_TREE at tree 5 -> all outputs at reset values immediately; next col_we restarts COLLECT.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the classify sequencer: default parameter values,
// the sequencer state encoding and a width helper for index signals.
package rf_pkg;

    localparam int NUM_DATA_DEF    = 40;
    localparam int NUM_TREES_DEF   = 8;
    localparam int NUM_CLASSES_DEF = 4;
    localparam int ADDR_W_DEF      = 14;
    localparam int DATA_W_DEF      = 14;
    localparam int TIMEOUT_DEF     = 1023;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COLLECT   = 3'd1,
        S_LAUNCH    = 3'd2,
        S_WAIT_TREE = 3'd3,
        S_TALLY     = 3'd4,
        S_REPORT    = 3'd5
    } state_t;

    // Index width for n items; never narrower than one bit so a
    // single-item configuration still yields a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vote_tally.sv
// Per-class vote counters with a combinational majority select.
// Ties go to the lowest class index; all-zero counters select class 0.
module vote_tally
    import rf_pkg::*;
#(
    parameter int NUM_TREES   = NUM_TREES_DEF,
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    localparam int CLS_W      = idx_w(NUM_CLASSES),
    localparam int VCNT_W     = $clog2(NUM_TREES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add,
    input  logic [CLS_W-1:0] vote,
    input  logic             clear,
    output logic [CLS_W-1:0] winner
);

    logic [VCNT_W-1:0] r_cnt [NUM_CLASSES];
    logic [VCNT_W-1:0] w_best_cnt;
    logic [CLS_W-1:0]  w_best_idx;

    // Count votes per class; saturate instead of wrapping, clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CLASSES; c++) r_cnt[c] <= '0;
        end else if (clear) begin
            for (int c = 0; c < NUM_CLASSES; c++) r_cnt[c] <= '0;
        end else if (add) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                if (vote == CLS_W'(c) && r_cnt[c] != '1) r_cnt[c] <= r_cnt[c] + VCNT_W'(1);
            end
        end
    end

    // Strictly-greater compare scanning upward keeps the lowest index on ties.
    always_comb begin
        w_best_cnt = r_cnt[0];
        w_best_idx = '0;
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (r_cnt[c] > w_best_cnt) begin
                w_best_cnt = r_cnt[c];
                w_best_idx = CLS_W'(c);
            end
        end
        winner = w_best_idx;
    end

endmodule

// File: rtl/classify_sequencer.sv
// Sequences one classification: collects a feature sample into a single-port
// memory, launches each tree in turn while serving its memory reads, counts
// the votes and reports the majority class.
//
// Tree read handshake: there is no ready; every tree_rd_req seen in
// WAIT_TREE is accepted that cycle, and tree_rd_valid is asserted exactly one
// cycle later with tree_rd_data carrying the memory output.
module classify_sequencer
    import rf_pkg::*;
#(
    parameter int NUM_DATA    = NUM_DATA_DEF,
    parameter int NUM_TREES   = NUM_TREES_DEF,
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    localparam int TIDX_W     = idx_w(NUM_TREES),
    localparam int CLS_W      = idx_w(NUM_CLASSES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              col_we,
    input  logic [ADDR_W-1:0] col_addr,
    input  logic [DATA_W-1:0] col_data,
    input  logic              col_finish,
    output logic              tree_start,
    output logic [TIDX_W-1:0] tree_idx,
    input  logic              tree_rd_req,
    input  logic [ADDR_W-1:0] tree_rd_addr,
    output logic              tree_rd_valid,
    output logic [DATA_W-1:0] tree_rd_data,
    input  logic              tree_done,
    input  logic [CLS_W-1:0]  tree_vote,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              calced,
    output logic [CLS_W-1:0]  result_class,
    output logic              busy,
    output logic              err_overrun,
    output logic              err_timeout
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    // A sample larger than the address space cannot be stored.
    if (NUM_DATA < 1 || NUM_DATA > (1 << ADDR_W)) begin : g_bad_num_data
        $error("classify_sequencer: NUM_DATA does not fit in ADDR_W");
    end

    state_t            r_state;
    state_t            w_next;
    logic [TIDX_W-1:0] r_tree;
    logic [WAIT_W-1:0] r_wait;
    logic              r_rd_valid;
    logic              r_err_overrun;
    logic              r_err_timeout;
    logic [CLS_W-1:0]  r_result;
    logic [CLS_W-1:0]  w_winner;
    logic              w_add;
    logic              w_clear;
    logic              w_last_tree;
    logic              w_timeout;
    logic              w_tree_end;
    logic              w_collecting;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;

    assign w_last_tree  = (r_tree == TIDX_W'(NUM_TREES - 1));
    assign w_timeout    = (r_state == S_WAIT_TREE) && !tree_done && (r_wait == WAIT_W'(TIMEOUT));
    assign w_tree_end   = (r_state == S_WAIT_TREE) && (tree_done || w_timeout);
    assign w_collecting = (r_state == S_IDLE) || (r_state == S_COLLECT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic plus the vote-add / vote-clear strobes.
    always_comb begin
        w_next  = r_state;
        w_add   = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            S_IDLE:      if (col_we) w_next = S_COLLECT;
            S_COLLECT:   if (col_finish) w_next = S_LAUNCH;
            S_LAUNCH:    w_next = S_WAIT_TREE;
            S_WAIT_TREE: begin
                w_add = tree_done;
                if (tree_done || w_timeout) w_next = w_last_tree ? S_TALLY : S_LAUNCH;
            end
            S_TALLY:     w_next = S_REPORT;
            S_REPORT: begin
                w_clear = 1'b1;
                w_next  = S_IDLE;
            end
            default:     w_next = S_IDLE;
        endcase
    end

    // Memory port mux: collector writes while collecting, tree reads while waiting.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = '0;
        if (w_collecting && col_we) begin
            w_mem_we   = 1'b1;
            w_mem_addr = col_addr;
        end else if (r_state == S_WAIT_TREE && tree_rd_req) begin
            w_mem_addr = tree_rd_addr;
        end
    end

    // Tree counter advances after each vote or timeout, cleared on report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             r_tree <= '0;
        else if (r_state == S_REPORT)        r_tree <= '0;
        else if (w_tree_end && !w_last_tree) r_tree <= r_tree + TIDX_W'(1);
    end

    // Wait counter restarts at each launch and holds once it reaches TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                      r_wait <= '0;
        else if (r_state == S_LAUNCH)                                 r_wait <= '0;
        else if (r_state == S_WAIT_TREE && r_wait != WAIT_W'(TIMEOUT)) r_wait <= r_wait + WAIT_W'(1);
    end

    // Read-valid trails each accepted tree read by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_valid <= 1'b0;
        else     r_rd_valid <= (r_state == S_WAIT_TREE) && tree_rd_req;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            if (col_we && !w_collecting) r_err_overrun <= 1'b1;
            if (w_timeout)               r_err_timeout <= 1'b1;
        end
    end

    // Result register loads the majority as TALLY hands over to REPORT, so it
    // is already valid during the calced pulse and holds until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_result <= '0;
        else if (r_state == S_TALLY) r_result <= w_winner;
    end

    vote_tally #(
        .NUM_TREES   (NUM_TREES),
        .NUM_CLASSES (NUM_CLASSES)
    ) u_vote_tally (
        .clk    (clk),
        .rst    (rst),
        .add    (w_add),
        .vote   (tree_vote),
        .clear  (w_clear),
        .winner (w_winner)
    );

    // Write enable is gated by reset so nothing reaches memory while held in reset.
    assign mem_we        = w_mem_we && !rst;
    assign mem_addr      = w_mem_addr;
    assign mem_wdata     = col_data;
    assign tree_start    = (r_state == S_LAUNCH);
    assign tree_idx      = r_tree;
    assign tree_rd_valid = r_rd_valid;
    assign tree_rd_data  = r_rd_valid ? mem_rdata : '0;
    assign calced        = (r_state == S_REPORT);
    assign result_class  = r_result;
    assign busy          = (r_state != S_IDLE);
    assign err_overrun   = r_err_overrun;
    assign err_timeout   = r_err_timeout;

endmodule

// File: tb/tb_classify_sequencer.sv
// Directed bench for classify_sequencer with a behavioural feature memory.
module tb_classify_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        col_we = 1'b0;
    logic [13:0] col_addr = '0;
    logic [13:0] col_data = '0;
    logic        col_finish = 1'b0;
    logic        tree_start;
    logic [2:0]  tree_idx;
    logic        tree_rd_req = 1'b0;
    logic [13:0] tree_rd_addr = '0;
    logic        tree_rd_valid;
    logic [13:0] tree_rd_data;
    logic        tree_done = 1'b0;
    logic [1:0]  tree_vote = '0;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [13:0] mem_wdata;
    logic [13:0] mem_rdata = '0;
    logic        calced;
    logic [1:0]  result_class;
    logic        busy;
    logic        err_overrun;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    logic [13:0] fmem [64];

    classify_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .col_we        (col_we),
        .col_addr      (col_addr),
        .col_data      (col_data),
        .col_finish    (col_finish),
        .tree_start    (tree_start),
        .tree_idx      (tree_idx),
        .tree_rd_req   (tree_rd_req),
        .tree_rd_addr  (tree_rd_addr),
        .tree_rd_valid (tree_rd_valid),
        .tree_rd_data  (tree_rd_data),
        .tree_done     (tree_done),
        .tree_vote     (tree_vote),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .calced        (calced),
        .result_class  (result_class),
        .busy          (busy),
        .err_overrun   (err_overrun),
        .err_timeout   (err_timeout)
    );

    // Clock.
    always #5 clk = ~clk;

    // Single-port feature memory, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) fmem[mem_addr[5:0]] <= mem_wdata;
        mem_rdata <= fmem[mem_addr[5:0]];
    end

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of test, required finish before 1000000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write words first..39, col_finish on the last; 0x1A5 at address 5 when special.
    task automatic collect(input int first, input bit special, input bit check);
        for (int i = first; i < 40; i++) begin
            col_we     = 1'b1;
            col_addr   = 14'(i);
            col_data   = (special && i == 5) ? 14'h1A5 : 14'(i);
            col_finish = (i == 39);
            #1;
            if (check) begin
                chk("col_mem_we", 32'(mem_we), 32'd1);
                chk("col_mem_addr", 32'(mem_addr), 32'(i));
                chk("col_mem_wdata", 32'(mem_wdata), 32'(i));
            end
            tick();
        end
        col_we     = 1'b0;
        col_finish = 1'b0;
        #1;
    endtask

    task automatic chk_launch(input int idx);
        chk("tree_start", 32'(tree_start), 32'd1);
        chk("tree_idx", 32'(tree_idx), 32'(idx));
    endtask

    // Called in WAIT_TREE: wait, then pulse tree_done with vote v.
    task automatic do_vote(input logic [1:0] v, input int delay);
        repeat (delay) tick();
        tree_done = 1'b1;
        tree_vote = v;
        tick();
        tree_done = 1'b0;
    endtask

    // Called in TALLY: check the report pulse and the held result.
    task automatic finish_sample(input logic [1:0] exp_cls);
        chk("tally_calced", 32'(calced), 32'd0);
        chk("tally_busy", 32'(busy), 32'd1);
        tick();
        chk("report_calced", 32'(calced), 32'd1);
        chk("report_class", 32'(result_class), 32'(exp_cls));
        tick();
        chk("after_calced", 32'(calced), 32'd0);
        chk("after_busy", 32'(busy), 32'd0);
        chk("held_class", 32'(result_class), 32'(exp_cls));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tree_start"}, 32'(tree_start), 32'd0);
        chk({tag, "_rd_valid"}, 32'(tree_rd_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(tree_rd_data), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_calced"}, 32'(calced), 32'd0);
        chk({tag, "_result"}, 32'(result_class), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err_overrun"}, 32'(err_overrun), 32'd0);
        chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
    endtask

    initial begin
        logic [1:0] votes [8];

        // Reset state.
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Sample 1: load data = addr, votes 2,2,1,2,3,2,0,1 -> class 2.
        collect(0, 1'b0, 1'b1);
        chk("launch_mem_we", 32'(mem_we), 32'd0);
        votes = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1};
        for (int t = 0; t < 8; t++) begin
            chk_launch(t);
            tick();
            chk("wait_tree_start", 32'(tree_start), 32'd0);
            if (t == 0) begin
                tree_rd_req  = 1'b1;
                tree_rd_addr = 14'd7;
                #1;
                chk("rd_mem_addr", 32'(mem_addr), 32'd7);
                chk("rd_mem_we", 32'(mem_we), 32'd0);
                tick();
                tree_rd_req = 1'b0;
                chk("rd_valid7", 32'(tree_rd_valid), 32'd1);
                chk("rd_data7", 32'(tree_rd_data), 32'd7);
            end
            do_vote(votes[t], t % 3);
        end
        finish_sample(2'd2);
        chk("s1_err_overrun", 32'(err_overrun), 32'd0);
        chk("s1_err_timeout", 32'(err_timeout), 32'd0);

        // Sample 2: 0x1A5 at addr 5, overrun during WAIT_TREE, 4-way tie -> class 0.
        collect(0, 1'b1, 1'b0);
        votes = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd2, 2'd2};
        for (int t = 0; t < 8; t++) begin
            chk_launch(t);
            tick();
            if (t == 0) begin
                tree_rd_req  = 1'b1;
                tree_rd_addr = 14'd5;
                tick();
                tree_rd_req = 1'b0;
                chk("rd_valid5", 32'(tree_rd_valid), 32'd1);
                chk("rd_data5", 32'(tree_rd_data), 32'h1A5);
                col_we   = 1'b1;
                col_addr = 14'd3;
                col_data = 14'h3FF;
                #1;
                chk("overrun_mem_we", 32'(mem_we), 32'd0);
                tick();
                col_we = 1'b0;
                chk("err_overrun_set", 32'(err_overrun), 32'd1);
                chk("rd_valid_drop", 32'(tree_rd_valid), 32'd0);
            end
            do_vote(votes[t], 1);
        end
        finish_sample(2'd0);

        // Sample 3: tree 3 times out with tree_vote held at 3, no vote counted.
        // Votes 1,1,1,-,3,3,3,0 -> tie 1/3 resolves to class 1.
        collect(0, 1'b0, 1'b0);
        votes = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        for (int t = 0; t < 8; t++) begin
            chk_launch(t);
            tick();
            if (t == 3) begin
                tree_vote = 2'd3;
                repeat (1023) tick();
                chk("pre_timeout_err", 32'(err_timeout), 32'd0);
                chk("pre_timeout_start", 32'(tree_start), 32'd0);
                tick();
                chk("err_timeout_set", 32'(err_timeout), 32'd1);
            end else begin
                do_vote(votes[t], 0);
            end
        end
        finish_sample(2'd1);
        chk("s3_err_timeout_sticky", 32'(err_timeout), 32'd1);
        chk("s3_err_overrun_sticky", 32'(err_overrun), 32'd1);

        // Sample 4: five votes for class 2, then reset mid-WAIT_TREE at tree 5.
        collect(0, 1'b0, 1'b0);
        for (int t = 0; t < 5; t++) begin
            chk_launch(t);
            tick();
            do_vote(2'd2, 0);
        end
        chk_launch(5);
        tick();
        tree_rd_req  = 1'b1;
        tree_rd_addr = 14'd2;
        tick();
        tree_rd_req = 1'b0;
        chk("pre_rst_rd_valid", 32'(tree_rd_valid), 32'd1);
        rst    = 1'b1;
        col_we = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        col_we = 1'b0;
        repeat (2) tick();

        // First cycle after reset: stray tree_done is ignored, col_we starts COLLECT.
        rst       = 1'b0;
        tree_done = 1'b1;
        tree_vote = 2'd2;
        col_we    = 1'b1;
        col_addr  = 14'd0;
        col_data  = 14'd0;
        #1;
        chk("post_rst_mem_we", 32'(mem_we), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        tick();
        tree_done = 1'b0;
        col_we    = 1'b0;
        #1;
        chk("collect_busy", 32'(busy), 32'd1);
        chk("collect_calced", 32'(calced), 32'd0);
        collect(1, 1'b0, 1'b0);

        // Votes 2,2,2,1,1,1,0,0 -> tie 1/2 resolves to class 1 (stale or stray
        // class-2 votes would make class 2 win).
        votes = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
        for (int t = 0; t < 8; t++) begin
            chk_launch(t);
            tick();
            do_vote(votes[t], 0);
        end
        finish_sample(2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
